// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for an RV32I subset (lw, sw, R/I ALU, beq, jal).
// Outputs are decoded from the current state. The one exception is branch pcwrite,
// which also depends on the ALU flags in the BRANCH cycle.
// Optional feature macro: BRANCH_EXT_EN adds bne/blt/bge to the branch decode.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       adrsrc,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [3:0] alucontrol,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLLI = 4'b0110;
  localparam logic [3:0] ALU_SRLI = 4'b0111;
  localparam logic [3:0] ALU_SRAI = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic       legal_s;
  logic       br_legal_s;
  logic       taken_s;
  logic [3:0] alu_rtype_s;
  logic [3:0] alu_itype_s;
  logic       pcwrite_s;
  logic       irwrite_s;
  logic       memwrite_s;
  logic       regwrite_s;
  logic       illegal_s;

  // State register; reset abandons any in-flight instruction and restarts at FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Immediate format select, purely from the opcode
  always_comb begin
    immsrc = 2'b00;
    case (op)
      OP_STORE:  immsrc = 2'b01;
      OP_BRANCH: immsrc = 2'b10;
      OP_JAL:    immsrc = 2'b11;
      default:   immsrc = 2'b00;
    endcase
  end

  // ALU operation for R-type and I-type; funct3=011 never reaches these states
  always_comb begin
    alu_rtype_s = ALU_ADD;
    alu_itype_s = ALU_ADD;
    case (funct3)
      3'b000:  begin alu_rtype_s = funct7b5 ? ALU_SUB : ALU_ADD; alu_itype_s = ALU_ADD; end
      3'b001:  begin alu_rtype_s = ALU_SLL; alu_itype_s = ALU_SLLI; end
      3'b010:  begin alu_rtype_s = ALU_SLT; alu_itype_s = ALU_SLT; end
      3'b100:  begin alu_rtype_s = ALU_XOR; alu_itype_s = ALU_XOR; end
      3'b101:  begin
        alu_rtype_s = funct7b5 ? ALU_SRA : ALU_SRL;
        alu_itype_s = funct7b5 ? ALU_SRAI : ALU_SRLI;
      end
      3'b110:  begin alu_rtype_s = ALU_OR; alu_itype_s = ALU_OR; end
      3'b111:  begin alu_rtype_s = ALU_AND; alu_itype_s = ALU_AND; end
      default: begin alu_rtype_s = ALU_ADD; alu_itype_s = ALU_ADD; end
    endcase
  end

`ifdef BRANCH_EXT_EN
  // Branch decode with bne/blt/bge: legality and taken outcome from the flags
  always_comb begin
    br_legal_s = 1'b0;
    taken_s    = 1'b0;
    case (funct3)
      3'b000:  begin br_legal_s = 1'b1; taken_s = zero;  end
      3'b001:  begin br_legal_s = 1'b1; taken_s = ~zero; end
      3'b100:  begin br_legal_s = 1'b1; taken_s = lt;    end
      3'b101:  begin br_legal_s = 1'b1; taken_s = ~lt;   end
      default: begin br_legal_s = 1'b0; taken_s = 1'b0;  end
    endcase
  end
`else
  logic unused_lt_s;
  assign unused_lt_s = lt;

  // Branch decode, beq only
  always_comb begin
    br_legal_s = 1'b0;
    taken_s    = 1'b0;
    case (funct3)
      3'b000:  begin br_legal_s = 1'b1; taken_s = zero; end
      default: begin br_legal_s = 1'b0; taken_s = 1'b0; end
    endcase
  end
`endif

  // Whole-instruction legality, evaluated in DECODE
  always_comb begin
    legal_s = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_JAL: legal_s = 1'b1;
      OP_RTYPE, OP_ITYPE:        legal_s = (funct3 != 3'b011);
      OP_BRANCH:                 legal_s = br_legal_s;
      default:                   legal_s = 1'b0;
    endcase
  end

  // Next-state and per-state control outputs; unlisted encodings fall back to FETCH
  always_comb begin
    state_next_s = FETCH;
    pcwrite_s    = 1'b0;
    irwrite_s    = 1'b0;
    memwrite_s   = 1'b0;
    regwrite_s   = 1'b0;
    illegal_s    = 1'b0;
    adrsrc       = 1'b0;
    resultsrc    = 2'b00;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    alucontrol   = ALU_ADD;
    case (state_r)
      FETCH: begin
        irwrite_s    = 1'b1;
        alusrcb      = 2'b10;
        resultsrc    = 2'b10;
        pcwrite_s    = 1'b1;
        state_next_s = DECODE;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        if (!legal_s) begin
          illegal_s    = 1'b1;
          state_next_s = FETCH;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_next_s = MEMADR;
            OP_RTYPE:          state_next_s = EXECR;
            OP_ITYPE:          state_next_s = EXECI;
            OP_BRANCH:         state_next_s = BRANCH;
            OP_JAL:            state_next_s = JAL;
            default:           state_next_s = FETCH;
          endcase
        end
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        if (op == OP_STORE) begin
          state_next_s = MEMWRITE;
        end else begin
          state_next_s = MEMREAD;
        end
      end
      MEMREAD: begin
        adrsrc       = 1'b1;
        state_next_s = MEMWB;
      end
      MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_s   = 1'b1;
        state_next_s = FETCH;
      end
      MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_s   = 1'b1;
        state_next_s = FETCH;
      end
      EXECR: begin
        alusrca      = 2'b10;
        alucontrol   = alu_rtype_s;
        state_next_s = ALUWB;
      end
      EXECI: begin
        alusrca      = 2'b10;
        alusrcb      = 2'b01;
        alucontrol   = alu_itype_s;
        state_next_s = ALUWB;
      end
      ALUWB: begin
        regwrite_s   = 1'b1;
        state_next_s = FETCH;
      end
      JAL: begin
        alusrca      = 2'b01;
        alusrcb      = 2'b10;
        pcwrite_s    = 1'b1;
        state_next_s = ALUWB;
      end
      BRANCH: begin
        alusrca      = 2'b10;
        alucontrol   = ALU_SUB;
        pcwrite_s    = taken_s;
        state_next_s = FETCH;
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  // Write enables and illegal are held low for as long as reset is asserted
  assign pcwrite  = pcwrite_s  & ~reset;
  assign irwrite  = irwrite_s  & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign illegal  = illegal_s  & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed vector table, hand-written reset sequences,
// and randomized instructions checked cycle by cycle against a per-class model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       lt;
  logic       pcwrite, irwrite, memwrite, regwrite, adrsrc, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [3:0] alucontrol;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .pcwrite(pcwrite), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .adrsrc(adrsrc), .resultsrc(resultsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .immsrc(immsrc), .alucontrol(alucontrol), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [3:0] alucontrol;
    logic       illegal;
  } outs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       l;
    int         cycles;
    logic [3:0] alu3;
    logic [3:0] flags;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  outs_t exp_q[$];
  vec_t  vecs[$];

  // Instruction classes used by the reference model
  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_BAD = 6;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t s;
    s = {pcwrite, irwrite, memwrite, regwrite, adrsrc, resultsrc, alusrca, alusrcb,
         immsrc, alucontrol, illegal};
    return s;
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BR) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit br_ok(input logic [2:0] f3);
`ifdef BRANCH_EXT_EN
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
`else
    return (f3 == 3'd0);
`endif
  endfunction

  function automatic bit br_taken(input logic [2:0] f3, input logic z, input logic l);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return l;
      3'd5:    return !l;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_r(input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return f7 ? 4'd1 : 4'd0;
      3'd1:    return 4'd9;
      3'd2:    return 4'd5;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd11 : 4'd10;
      3'd6:    return 4'd3;
      3'd7:    return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] alu_i(input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return 4'd0;
      3'd1:    return 4'd6;
      3'd2:    return 4'd5;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd8 : 4'd7;
      3'd6:    return 4'd3;
      3'd7:    return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

  function automatic int kind_of(input logic [6:0] o, input logic [2:0] f3);
    if (o == LW) return K_LOAD;
    if (o == SW) return K_STORE;
    if (o == RT) return (f3 == 3'd3) ? K_BAD : K_R;
    if (o == IT) return (f3 == 3'd3) ? K_BAD : K_I;
    if (o == BR) return br_ok(f3) ? K_BR : K_BAD;
    if (o == JL) return K_JAL;
    return K_BAD;
  endfunction

  function automatic outs_t mk(input logic [6:0] o, input logic pw, input logic irw,
                               input logic mw, input logic rw, input logic adr,
                               input logic [1:0] rs, input logic [1:0] sa,
                               input logic [1:0] sb, input logic [3:0] alu, input logic ill);
    outs_t s;
    s = {pw, irw, mw, rw, adr, rs, sa, sb, imm_of(o), alu, ill};
    return s;
  endfunction

  // Reference: per-cycle expected outputs for one instruction, from its class
  function automatic void model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic z, input logic l);
    int k;
    k = kind_of(o, f3);
    exp_q.delete();
    exp_q.push_back(mk(o, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'd0, 0));
    exp_q.push_back(mk(o, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, k == K_BAD));
    case (k)
      K_LOAD: begin
        exp_q.push_back(mk(o, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0));
        exp_q.push_back(mk(o, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, 0));
        exp_q.push_back(mk(o, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 4'd0, 0));
      end
      K_STORE: begin
        exp_q.push_back(mk(o, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0));
        exp_q.push_back(mk(o, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, 0));
      end
      K_R: begin
        exp_q.push_back(mk(o, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_r(f3, f7), 0));
        exp_q.push_back(mk(o, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0));
      end
      K_I: begin
        exp_q.push_back(mk(o, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_i(f3, f7), 0));
        exp_q.push_back(mk(o, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0));
      end
      K_JAL: begin
        exp_q.push_back(mk(o, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0, 0));
        exp_q.push_back(mk(o, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0));
      end
      K_BR: begin
        exp_q.push_back(mk(o, br_taken(f3, z, l), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd1, 0));
      end
      default: begin
      end
    endcase
  endfunction

  // Applies one instruction starting in FETCH and checks every cycle until the next FETCH
  task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input logic l,
                           output int ncyc, output logic [3:0] alu3, output logic [3:0] flg);
    outs_t got;
    int    c;
    bit    done;
    model(o, f3, f7, z, l);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; lt = l;
    alu3 = 4'd0; flg = 4'd0; done = 1'b0; c = 0;
    while (!done) begin
      #1;
      got = sample();
      if (c > 0 && got.irwrite) begin
        done = 1'b1;
      end else if (c >= 12) begin
        done = 1'b1;
        checks++;
        errors++;
        $display("FAIL %s timeout: no FETCH after %0d cycles, required %0d", nm, c, exp_q.size());
      end else begin
        if (c < exp_q.size()) check($sformatf("%s cyc%0d", nm, c), 32'(got), 32'(exp_q[c]));
        if (c == 2) alu3 = got.alucontrol;
        flg = {got.pcwrite, got.memwrite, got.regwrite, got.illegal};
        c++;
        @(negedge clk);
      end
    end
    ncyc = c;
    check($sformatf("%s cycles", nm), 32'(ncyc), 32'(exp_q.size()));
  endtask

  function automatic void add_vec(input string nm, input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z, input logic l, input int cyc,
                                  input logic [3:0] a3, input logic [3:0] fl);
    vec_t v;
    v.name = nm; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.l = l;
    v.cycles = cyc; v.alu3 = a3; v.flags = fl;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nc;
    logic [3:0] a3;
    logic [3:0] fl;
    outs_t      e;

    // flags column is {pcwrite, memwrite, regwrite, illegal} in the last cycle
    add_vec("lw",        LW,  3'd2, 1'b0, 1'b0, 1'b0, 5, 4'b0000, 4'b0010);
    add_vec("sw",        SW,  3'd2, 1'b0, 1'b0, 1'b0, 4, 4'b0000, 4'b0100);
    add_vec("r_sub",     RT,  3'd0, 1'b1, 1'b0, 1'b0, 4, 4'b0001, 4'b0010);
    add_vec("r_add",     RT,  3'd0, 1'b0, 1'b0, 1'b0, 4, 4'b0000, 4'b0010);
    add_vec("r_sll",     RT,  3'd1, 1'b0, 1'b0, 1'b0, 4, 4'b1001, 4'b0010);
    add_vec("r_slt",     RT,  3'd2, 1'b0, 1'b0, 1'b0, 4, 4'b0101, 4'b0010);
    add_vec("r_xor",     RT,  3'd4, 1'b0, 1'b0, 1'b0, 4, 4'b0100, 4'b0010);
    add_vec("r_srl",     RT,  3'd5, 1'b0, 1'b0, 1'b0, 4, 4'b1010, 4'b0010);
    add_vec("r_sra",     RT,  3'd5, 1'b1, 1'b0, 1'b0, 4, 4'b1011, 4'b0010);
    add_vec("r_or",      RT,  3'd6, 1'b0, 1'b0, 1'b0, 4, 4'b0011, 4'b0010);
    add_vec("r_and",     RT,  3'd7, 1'b0, 1'b0, 1'b0, 4, 4'b0010, 4'b0010);
    add_vec("i_srai",    IT,  3'd5, 1'b1, 1'b0, 1'b0, 4, 4'b1000, 4'b0010);
    add_vec("i_srli",    IT,  3'd5, 1'b0, 1'b0, 1'b0, 4, 4'b0111, 4'b0010);
    add_vec("i_addf7",   IT,  3'd0, 1'b1, 1'b0, 1'b0, 4, 4'b0000, 4'b0010);
    add_vec("i_slli",    IT,  3'd1, 1'b0, 1'b0, 1'b0, 4, 4'b0110, 4'b0010);
    add_vec("jal",       JL,  3'd0, 1'b0, 1'b0, 1'b0, 4, 4'b0000, 4'b0010);
    add_vec("beq_t",     BR,  3'd0, 1'b0, 1'b1, 1'b0, 3, 4'b0001, 4'b1000);
    add_vec("beq_nt",    BR,  3'd0, 1'b0, 1'b0, 1'b0, 3, 4'b0001, 4'b0000);
`ifdef BRANCH_EXT_EN
    add_vec("blt_t",     BR,  3'd4, 1'b0, 1'b0, 1'b1, 3, 4'b0001, 4'b1000);
    add_vec("bne_t",     BR,  3'd1, 1'b0, 1'b0, 1'b0, 3, 4'b0001, 4'b1000);
    add_vec("bge_nt",    BR,  3'd5, 1'b0, 1'b0, 1'b1, 3, 4'b0001, 4'b0000);
`else
    add_vec("blt_ill",   BR,  3'd4, 1'b0, 1'b0, 1'b1, 2, 4'b0000, 4'b0001);
    add_vec("bne_ill",   BR,  3'd1, 1'b0, 1'b0, 1'b0, 2, 4'b0000, 4'b0001);
`endif
    add_vec("bad_op",    BAD, 3'd0, 1'b0, 1'b0, 1'b0, 2, 4'b0000, 4'b0001);
    add_vec("r_f3_011",  RT,  3'd3, 1'b0, 1'b0, 1'b0, 2, 4'b0000, 4'b0001);
    add_vec("i_f3_011",  IT,  3'd3, 1'b0, 1'b0, 1'b0, 2, 4'b0000, 4'b0001);
    add_vec("lw_again",  LW,  3'd2, 1'b0, 1'b0, 1'b0, 5, 4'b0000, 4'b0010);

    // Reset held for two cycles: enables and illegal stay low
    reset = 1'b1; op = LW; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0; lt = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check("reset_enables", 32'({pcwrite, irwrite, memwrite, regwrite, illegal}), 32'd0);
    end
    reset = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run_instr(vecs[i].name, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].l,
                nc, a3, fl);
      check($sformatf("%s tbl_cycles", vecs[i].name), 32'(nc), 32'(vecs[i].cycles));
      if (vecs[i].cycles >= 3) check($sformatf("%s tbl_alu", vecs[i].name), 32'(a3), 32'(vecs[i].alu3));
      check($sformatf("%s tbl_flags", vecs[i].name), 32'(fl), 32'(vecs[i].flags));
    end

    // Reset asserted during MEMWRITE: memwrite suppressed, then FETCH
    model(SW, 3'd2, 1'b0, 1'b0, 1'b0);
    op = SW; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0; lt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("sw_rst cyc%0d", c), 32'(sample()), 32'(exp_q[c]));
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    e = exp_q[3];
    e.memwrite = 1'b0;
    check("rst_in_memwrite", 32'(sample()), 32'(e));
    @(negedge clk);
    #1;
    e = exp_q[0];
    e.pcwrite = 1'b0;
    e.irwrite = 1'b0;
    check("rst_to_fetch", 32'(sample()), 32'(e));
    reset = 1'b0;
    run_instr("after_rst", RT, 3'd0, 1'b1, 1'b0, 1'b0, nc, a3, fl);
    check("after_rst alu", 32'(a3), 32'd1);

    // Reset during DECODE of a load abandons it
    op = LW; funct3 = 3'd2;
    #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_in_decode", 32'({pcwrite, irwrite, memwrite, regwrite, illegal}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_instr("after_rst2", LW, 3'd2, 1'b0, 1'b0, 1'b0, nc, a3, fl);

    // Randomized instructions against the model
    for (int i = 0; i < 200; i++) begin
      logic [6:0] o;
      case ($urandom_range(0, 7))
        0:       o = LW;
        1:       o = SW;
        2:       o = RT;
        3:       o = IT;
        4:       o = BR;
        5:       o = JL;
        6:       o = 7'($urandom);
        default: o = BR;
      endcase
      run_instr($sformatf("rnd%0d", i), o, 3'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), nc, a3, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port op, input, 7 bits: the instruction opcode, taken from the instruction register.
REQ-004 SHALL have port funct3, input, 3 bits, and port funct7b5, input, 1 bit (instruction bit 30).
REQ-005 SHALL have port zero, input, 1 bit, and port lt, input, 1 bit: the ALU flags for the current cycle.
REQ-006 SHALL have port pcwrite, output, 1 bit: PC register enable.
REQ-007 SHALL have ports irwrite, memwrite and regwrite, outputs, 1 bit each: write enables.
REQ-008 SHALL have port adrsrc, output, 1 bit: memory address select; 0 = PC, 1 = result.
REQ-009 SHALL have port resultsrc, output, 2 bits: 00 = registered ALU out, 01 = memory data, 10 = ALU result.
REQ-010 SHALL have port alusrca, output, 2 bits: 00 = PC, 01 = old PC, 10 = register rs1.
REQ-011 SHALL have port alusrcb, output, 2 bits: 00 = register rs2, 01 = immediate, 10 = constant 4.
REQ-012 SHALL have port immsrc, output, 2 bits, decoded from op: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-013 SHALL have port alucontrol, output, 4 bits. Encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 slli, 0111 srli, 1000 srai, 1001 sll, 1010 srl, 1011 sra.
REQ-014 SHALL have port illegal, output, 1 bit: single-cycle pulse on an unsupported instruction.

Function
REQ-015 SHALL be a Moore FSM with one Mealy term (branch pcwrite), using states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
REQ-016 FETCH SHALL drive adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, add, resultsrc=10 and pcwrite=1, then go to DECODE.
REQ-017 DECODE SHALL drive alusrca=01, alusrcb=01 and add (branch/jump target), then dispatch on op as follows:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- anything else -> FETCH with illegal=1 and no write enable asserted
REQ-018 MEMADR SHALL drive alusrca=10, alusrcb=01 and add, then go to MEMREAD for a load or MEMWRITE for a store.
REQ-019 MEMREAD SHALL drive resultsrc=00 and adrsrc=1, then go to MEMWB.
REQ-020 MEMWB SHALL drive resultsrc=01 and regwrite=1, then go to FETCH.
REQ-021 MEMWRITE SHALL drive resultsrc=00, adrsrc=1 and memwrite=1, then go to FETCH.
REQ-022 EXECR SHALL drive alusrca=10 and alusrcb=00; EXECI SHALL drive alusrca=10 and alusrcb=01; both SHALL then go to ALUWB.
REQ-023 ALUWB SHALL drive resultsrc=00 and regwrite=1, then go to FETCH.
REQ-024 JAL SHALL drive alusrca=01, alusrcb=10, add, resultsrc=00 and pcwrite=1, then go to ALUWB.
REQ-025 BRANCH SHALL drive alusrca=10, alusrcb=00, sub and resultsrc=00, set pcwrite=taken in the same cycle, then go to FETCH.
- funct3 000 (beq): taken = zero
REQ-026 R-type alucontrol by funct3:
- 000: sub if funct7b5 else add
- 001: sll
- 010: slt
- 100: xor
- 101: sra if funct7b5 else srl
- 110: or
- 111: and
REQ-027 I-type alucontrol by funct3:
- 000: add (funct7b5 ignored)
- 001: slli
- 010: slt
- 100: xor
- 101: srai if funct7b5 else srli
- 110: or
- 111: and
REQ-028 funct3=011 in R-type or I-type SHALL be treated as illegal at DECODE, per REQ-017.
REQ-029 Each instruction class SHALL take a fixed number of cycles: lw 5, sw 4, R/I 4, jal 4, branch 3, illegal 2.
REQ-030 Every state not listed in REQ-016 to REQ-025 SHALL drive all enables 0 and alucontrol=0000; an unreachable state encoding SHALL recover to FETCH on the next edge.

Reset
REQ-031 While reset=1, all write enables and illegal SHALL be 0 and the state SHALL load FETCH at the edge.
REQ-032 An in-flight instruction SHALL be abandoned when reset asserts; the first cycle after reset deasserts SHALL be FETCH.

Configuration
REQ-033 Macro BRANCH_EXT_EN defined: branch funct3 SHALL decode as follows:
- 001 (bne): taken = ~zero
- 100 (blt): taken = lt
- 101 (bge): taken = ~lt
REQ-034 Macro BRANCH_EXT_EN undefined: only beq SHALL be supported; any other branch funct3 SHALL be illegal at DECODE.

Verification
REQ-035 Bench SHALL check: reset held 2 cycles, then lw (op 0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regwrite=1 only in cycle 5.
REQ-036 Bench SHALL check: R-type with funct3=000, funct7b5=1 -> alucontrol=0001 in EXECR; regwrite=1 in the next cycle.
REQ-037 Bench SHALL check: I-type with funct3=101, funct7b5=1 -> alucontrol=1000; same with funct7b5=0 -> 0111.
REQ-038 Bench SHALL check: beq with zero=1 in BRANCH -> pcwrite=1; with zero=0 -> pcwrite=0; both return to FETCH.
REQ-039 Bench SHALL check, with BRANCH_EXT_EN: blt with lt=1 -> pcwrite=1. Without the macro: the same instruction -> illegal=1 in DECODE, no enable asserted.
REQ-040 Bench SHALL check: op=1111111 -> illegal pulses 1 cycle, then FETCH; reset asserted during MEMWRITE -> memwrite=0 that cycle, then FETCH.
